// File: rtl/sr_flop_bank_if.sv
// sr_flop_bank_if: request/status bundle for sr_flop_bank.
//   en, s, r       per-channel enable, set and reset requests (N bits each)
//   clr_conflict   synchronous clear of the conflict status
//   q, qn          stored state and its complement
//   conflict_flag  sticky per-channel conflict indication
//   conflict_cnt   saturating count of cycles that had any conflict
interface sr_flop_bank_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  logic [N-1:0]     en;
  logic [N-1:0]     s;
  logic [N-1:0]     r;
  logic             clr_conflict;
  logic [N-1:0]     q;
  logic [N-1:0]     qn;
  logic [N-1:0]     conflict_flag;
  logic [CNT_W-1:0] conflict_cnt;
  modport master (
    output en, s, r, clr_conflict,
    input  q, qn, conflict_flag, conflict_cnt
  );
  modport slave (
    input  en, s, r, clr_conflict,
    output q, qn, conflict_flag, conflict_cnt
  );
endinterface

// File: rtl/sr_flop_bank.sv
// sr_flop_bank: N clocked set/reset channels with deterministic S=R=1 handling and conflict status.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    sr_flop_bank_if slave: en/s/r/clr_conflict in, q/qn/conflict_flag/conflict_cnt out
module sr_flop_bank #(
  parameter int             N         = 4,
  parameter int             BOTH_MODE = 2,
  parameter logic [N-1:0]   RESET_VAL = '0,
  parameter int             CNT_W     = 8
) (
  input logic           clk,
  input logic           rst_n,
  sr_flop_bank_if.slave bus
);
  if (BOTH_MODE < 0 || BOTH_MODE > 3) begin : g_bad_mode
    $error("sr_flop_bank: BOTH_MODE must be 0..3");
  end
  if (N < 1 || N > 32) begin : g_bad_n
    $error("sr_flop_bank: N must be 1..32");
  end
  logic [N-1:0]     q_q, q_d;
  logic [N-1:0]     flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic [N-1:0]     conf, both, upd;
  always_comb begin
    conf     = bus.en & bus.s & bus.r;
    both     = BOTH_MODE == 0 ? q_q : BOTH_MODE == 1 ? {N{1'b1}} : BOTH_MODE == 2 ? {N{1'b0}} : ~q_q;
    // value each channel takes when enabled: set, reset, S=R=1 action, or hold when idle
    upd      = (bus.s & ~bus.r) | (bus.s & bus.r & both) | (~bus.s & ~bus.r & q_q);
    q_d      = (bus.en & upd) | (~bus.en & q_q);
    // a conflict in the clearing cycle survives the clear
    flag_d   = (bus.clr_conflict ? {N{1'b0}} : flag_q) | conf;
    cnt_base = bus.clr_conflict ? {CNT_W{1'b0}} : cnt_q;
    cnt_d    = cnt_base + CNT_W'(|conf && !(&cnt_base));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= RESET_VAL;
      flag_q <= '0;
      cnt_q  <= '0;
    end else begin
      q_q    <= q_d;
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end
  assign bus.q             = q_q;
  assign bus.qn            = ~q_q;
  assign bus.conflict_flag = flag_q;
  assign bus.conflict_cnt  = cnt_q;
endmodule

// File: tb/tb_sr_flop_bank.sv
// tb_sr_flop_bank: directed checks of sr_flop_bank across all S=R=1 modes and a narrow counter.
module tb_sr_flop_bank;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] en = '0, s = '0, r = '0;
  logic       clr = 1'b0;
  int         cmp = 0, bad = 0;

  always #5 clk = ~clk;

  sr_flop_bank_if #(.N(4), .CNT_W(8)) b0 ();
  sr_flop_bank_if #(.N(4), .CNT_W(8)) b1 ();
  sr_flop_bank_if #(.N(4), .CNT_W(8)) b2 ();
  sr_flop_bank_if #(.N(4), .CNT_W(8)) b3 ();
  sr_flop_bank_if #(.N(4), .CNT_W(3)) bs ();

  assign {b0.en, b0.s, b0.r, b0.clr_conflict} = {en, s, r, clr};
  assign {b1.en, b1.s, b1.r, b1.clr_conflict} = {en, s, r, clr};
  assign {b2.en, b2.s, b2.r, b2.clr_conflict} = {en, s, r, clr};
  assign {b3.en, b3.s, b3.r, b3.clr_conflict} = {en, s, r, clr};
  assign {bs.en, bs.s, bs.r, bs.clr_conflict} = {en, s, r, clr};

  sr_flop_bank #(.N(4), .BOTH_MODE(0), .RESET_VAL(4'b1010), .CNT_W(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  sr_flop_bank #(.N(4), .BOTH_MODE(1), .RESET_VAL(4'b1010), .CNT_W(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  sr_flop_bank #(.N(4), .BOTH_MODE(2), .RESET_VAL(4'b1010), .CNT_W(8)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
  sr_flop_bank #(.N(4), .BOTH_MODE(3), .RESET_VAL(4'b1010), .CNT_W(8)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));
  sr_flop_bank #(.N(4), .BOTH_MODE(2), .RESET_VAL(4'b0011), .CNT_W(3)) us (.clk(clk), .rst_n(rst_n), .bus(bs.slave));

  task automatic step(input logic [3:0] e, input logic [3:0] ss, input logic [3:0] rr, input logic c);
    en = e; s = ss; r = rr; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cmp++; if (b2.q !== 4'b1010) begin bad++; $display("FAIL reset_init_q got %b want 1010", b2.q); end
    step(4'b1111, 4'b0101, 4'b1010, 1'b0);
    cmp++; if (b2.q !== 4'b0101) begin bad++; $display("FAIL reset_load_q got %b want 0101", b2.q); end
    step(4'b0001, 4'b0001, 4'b0001, 1'b0);
    cmp++; if (b2.conflict_cnt !== 8'd1) begin bad++; $display("FAIL reset_pre_cnt got %0d want 1", b2.conflict_cnt); end
    rst_n = 1'b0;
    #2;
    cmp++; if (b2.q !== 4'b1010) begin bad++; $display("FAIL reset_async_q got %b want 1010", b2.q); end
    cmp++; if (b2.qn !== 4'b0101) begin bad++; $display("FAIL reset_async_qn got %b want 0101", b2.qn); end
    cmp++; if (b2.conflict_flag !== 4'b0000) begin bad++; $display("FAIL reset_async_flag got %b want 0000", b2.conflict_flag); end
    cmp++; if (b2.conflict_cnt !== 8'd0) begin bad++; $display("FAIL reset_async_cnt got %0d want 0", b2.conflict_cnt); end
    cmp++; if (b3.q !== 4'b1010) begin bad++; $display("FAIL reset_async_q_m3 got %b want 1010", b3.q); end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_enable;
    step(4'b1111, 4'b0000, 4'b1111, 1'b0);
    cmp++; if (b2.q !== 4'b0000) begin bad++; $display("FAIL en_clear_q got %b want 0000", b2.q); end
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 4'b1111, 4'b0000, 1'b0);
      cmp++; if (b2.q !== 4'b0000) begin bad++; $display("FAIL en_gated_q cycle %0d got %b want 0000", i, b2.q); end
    end
    step(4'b0011, 4'b1111, 4'b0000, 1'b0);
    cmp++; if (b2.q !== 4'b0011) begin bad++; $display("FAIL en_partial_q got %b want 0011", b2.q); end
    cmp++; if (b2.qn !== 4'b1100) begin bad++; $display("FAIL en_partial_qn got %b want 1100", b2.qn); end
    step(4'b0000, 4'b1111, 4'b1111, 1'b0);
    cmp++; if (b2.q !== 4'b0011) begin bad++; $display("FAIL en_off_conflict_q got %b want 0011", b2.q); end
    cmp++; if (b2.conflict_flag !== 4'b0000) begin bad++; $display("FAIL en_off_flag got %b want 0000", b2.conflict_flag); end
    cmp++; if (b2.conflict_cnt !== 8'd0) begin bad++; $display("FAIL en_off_cnt got %0d want 0", b2.conflict_cnt); end
  endtask

  task automatic test_modes;
    step(4'b1111, 4'b0101, 4'b1010, 1'b0);
    step(4'b1111, 4'b1111, 4'b1111, 1'b0);
    cmp++; if (b0.q !== 4'b0101) begin bad++; $display("FAIL mode0_q got %b want 0101", b0.q); end
    cmp++; if (b1.q !== 4'b1111) begin bad++; $display("FAIL mode1_q got %b want 1111", b1.q); end
    cmp++; if (b1.qn !== 4'b0000) begin bad++; $display("FAIL mode1_qn got %b want 0000", b1.qn); end
    cmp++; if (b2.q !== 4'b0000) begin bad++; $display("FAIL mode2_q got %b want 0000", b2.q); end
    cmp++; if (b3.q !== 4'b1010) begin bad++; $display("FAIL mode3_q1 got %b want 1010", b3.q); end
    step(4'b1111, 4'b1111, 4'b1111, 1'b0);
    cmp++; if (b3.q !== 4'b0101) begin bad++; $display("FAIL mode3_q2 got %b want 0101", b3.q); end
    cmp++; if (b0.q !== 4'b0101) begin bad++; $display("FAIL mode0_q2 got %b want 0101", b0.q); end
    cmp++; if (b2.conflict_cnt !== 8'd2) begin bad++; $display("FAIL mode_cnt got %0d want 2", b2.conflict_cnt); end
    step(4'b0000, 4'b0000, 4'b0000, 1'b1);
    cmp++; if (b2.conflict_flag !== 4'b0000) begin bad++; $display("FAIL mode_clr_flag got %b want 0000", b2.conflict_flag); end
    cmp++; if (b2.conflict_cnt !== 8'd0) begin bad++; $display("FAIL mode_clr_cnt got %0d want 0", b2.conflict_cnt); end
  endtask

  task automatic test_conflict;
    step(4'b0100, 4'b0100, 4'b0100, 1'b0);
    cmp++; if (b2.conflict_flag !== 4'b0100) begin bad++; $display("FAIL conf_ch2_flag got %b want 0100", b2.conflict_flag); end
    cmp++; if (b2.conflict_cnt !== 8'd1) begin bad++; $display("FAIL conf_ch2_cnt got %0d want 1", b2.conflict_cnt); end
    step(4'b0101, 4'b0101, 4'b0101, 1'b0);
    cmp++; if (b2.conflict_flag !== 4'b0101) begin bad++; $display("FAIL conf_multi_flag got %b want 0101", b2.conflict_flag); end
    cmp++; if (b2.conflict_cnt !== 8'd2) begin bad++; $display("FAIL conf_multi_cnt got %0d want 2", b2.conflict_cnt); end
  endtask

  task automatic test_clear;
    step(4'b0010, 4'b0010, 4'b0010, 1'b1);
    cmp++; if (b2.conflict_flag !== 4'b0010) begin bad++; $display("FAIL clr_new_flag got %b want 0010", b2.conflict_flag); end
    cmp++; if (b2.conflict_cnt !== 8'd1) begin bad++; $display("FAIL clr_new_cnt got %0d want 1", b2.conflict_cnt); end
    step(4'b0000, 4'b0000, 4'b0000, 1'b1);
    cmp++; if (b2.conflict_flag !== 4'b0000) begin bad++; $display("FAIL clr_only_flag got %b want 0000", b2.conflict_flag); end
    cmp++; if (b2.conflict_cnt !== 8'd0) begin bad++; $display("FAIL clr_only_cnt got %0d want 0", b2.conflict_cnt); end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 10; i++) begin
      step(4'b0001, 4'b0001, 4'b0001, 1'b0);
      cmp++; if (bs.conflict_cnt !== 3'(i < 7 ? i + 1 : 7)) begin bad++; $display("FAIL sat_cnt cycle %0d got %0d want %0d", i, bs.conflict_cnt, (i < 7 ? i + 1 : 7)); end
    end
    step(4'b0001, 4'b0001, 4'b0001, 1'b0);
    rst_n = 1'b0;
    #2;
    cmp++; if (bs.conflict_cnt !== 3'd0) begin bad++; $display("FAIL sat_rst_cnt got %0d want 0", bs.conflict_cnt); end
    cmp++; if (bs.conflict_flag !== 4'b0000) begin bad++; $display("FAIL sat_rst_flag got %b want 0000", bs.conflict_flag); end
    cmp++; if (bs.q !== 4'b0011) begin bad++; $display("FAIL sat_rst_q got %b want 0011", bs.q); end
    #1 rst_n = 1'b1;
    step(4'b0001, 4'b0001, 4'b0001, 1'b0);
    cmp++; if (bs.conflict_cnt !== 3'd1) begin bad++; $display("FAIL sat_restart_cnt got %0d want 1", bs.conflict_cnt); end
    cmp++; if (bs.q !== 4'b0010) begin bad++; $display("FAIL sat_restart_q got %b want 0010", bs.q); end
  endtask

  initial begin
    #12 rst_n = 1'b1;
    test_reset();
    test_enable();
    test_modes();
    test_conflict();
    test_clear();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
